// File: rtl/regfile_pkg.sv
// Shared widths, the hardwired-zero register index and the write-port arbiter state.
package regfile_pkg;
   localparam int DATA_W   = 32;
   localparam int ADDR_W   = 5;
   localparam int ZERO_REG = 0;

   typedef enum logic {
      NORMAL   = 1'b0,
      A_FORCED = 1'b1
   } arb_state_t;
endpackage

// File: rtl/regfile_scoreboard.sv
// Register busy scoreboard: set on issue, clear on commit. The hazard check is
// combinational; Busy updates one edge later. A stalled issue leaves Busy unchanged.
module regfile_scoreboard #(
   parameter int ADDR_W = regfile_pkg::ADDR_W,
   parameter int NREGS  = 1 << ADDR_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              issue_valid,
   input  logic [ADDR_W-1:0] issue_reg,
   input  logic [ADDR_W-1:0] src_reg_1,
   input  logic [ADDR_W-1:0] src_reg_2,
   input  logic              clr_en,
   input  logic [ADDR_W-1:0] clr_reg,
   output logic              stall,
   output logic [NREGS-1:0]  busy
);
   import regfile_pkg::*;

   localparam logic [ADDR_W-1:0] ZERO = ADDR_W'(ZERO_REG);

   logic [NREGS-1:0] busy_q;
   logic [NREGS-1:0] set_mask;
   logic [NREGS-1:0] clr_mask;
   logic             haz_1;
   logic             haz_2;
   logic             haz_waw;

   assign haz_1   = (src_reg_1 != ZERO) && busy_q[src_reg_1];
   assign haz_2   = (src_reg_2 != ZERO) && busy_q[src_reg_2];
   assign haz_waw = (issue_reg != ZERO) && busy_q[issue_reg];
   assign stall   = issue_valid && (haz_1 || haz_2 || haz_waw);

   assign set_mask = (issue_valid && !stall && issue_reg != ZERO) ?
                     (NREGS'(1) << issue_reg) : '0;
   assign clr_mask = clr_en ? (NREGS'(1) << clr_reg) : '0;

   // Set is applied after clear so a same-edge issue to the committing register stays busy.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_q <= '0;
      end else begin
         busy_q <= (busy_q & ~clr_mask) | set_mask;
      end
   end

   assign busy = busy_q;
endmodule

// File: rtl/regfile_write_arbiter.sv
// Two-port writeback arbiter (load over ALU, with ALU anti-starvation) feeding a
// registered RF write port; 1-cycle write latency; Ready is combinational per cycle.
module regfile_write_arbiter #(
   parameter int DATA_W     = regfile_pkg::DATA_W,
   parameter int ADDR_W     = regfile_pkg::ADDR_W,
   parameter int STARVE_MAX = 3
) (
   input  logic                   Clock,
   input  logic                   Reset_n,
   input  logic                   A_Valid,
   input  logic [ADDR_W-1:0]      A_Reg,
   input  logic [DATA_W-1:0]      A_Data,
   output logic                   A_Ready,
   input  logic                   B_Valid,
   input  logic [ADDR_W-1:0]      B_Reg,
   input  logic [DATA_W-1:0]      B_Data,
   output logic                   B_Ready,
   input  logic                   Issue_Valid,
   input  logic [ADDR_W-1:0]      Issue_Reg,
   input  logic [ADDR_W-1:0]      Src_Reg_1,
   input  logic [ADDR_W-1:0]      Src_Reg_2,
   output logic                   Stall,
   output logic                   Reg_Write,
   output logic [ADDR_W-1:0]      Write_Reg,
   output logic [DATA_W-1:0]      Write_Data,
   output logic [(1<<ADDR_W)-1:0] Busy
);
   import regfile_pkg::*;

   localparam int CNT_W = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
   localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(STARVE_MAX);
   localparam logic [ADDR_W-1:0] ZERO    = ADDR_W'(ZERO_REG);

   arb_state_t        state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              a_ready, b_ready;
   logic              wr_en_q;
   logic [ADDR_W-1:0] wr_reg_q;
   logic [DATA_W-1:0] wr_dat_q;

   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q <= NORMAL;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Grants are gated by Reset_n so nothing handshakes while reset is asserted.
   always_comb begin
      a_ready = 1'b0;
      b_ready = 1'b0;
      cnt_d   = cnt_q;
      state_d = state_q;
      if (Reset_n) begin
         if (state_q == A_FORCED) begin
            a_ready = A_Valid;
            b_ready = B_Valid && !A_Valid;
         end else begin
            b_ready = B_Valid;
            a_ready = A_Valid && !B_Valid;
         end
      end
      if (!A_Valid || a_ready) begin
         cnt_d = '0;
      end else if (cnt_q != CNT_MAX) begin
         cnt_d = cnt_q + 1'b1;
      end
      state_d = (cnt_d == CNT_MAX) ? A_FORCED : NORMAL;
   end

   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         wr_en_q  <= 1'b0;
         wr_reg_q <= '0;
         wr_dat_q <= '0;
      end else if (a_ready) begin
         wr_en_q  <= (A_Reg != ZERO);
         wr_reg_q <= A_Reg;
         wr_dat_q <= A_Data;
      end else if (b_ready) begin
         wr_en_q  <= (B_Reg != ZERO);
         wr_reg_q <= B_Reg;
         wr_dat_q <= B_Data;
      end else begin
         wr_en_q  <= 1'b0;
      end
   end

   assign A_Ready    = a_ready;
   assign B_Ready    = b_ready;
   assign Reg_Write  = wr_en_q;
   assign Write_Reg  = wr_reg_q;
   assign Write_Data = wr_dat_q;

   regfile_scoreboard #(
      .ADDR_W (ADDR_W)
   ) u_scoreboard (
      .clk         (Clock),
      .rst_n       (Reset_n),
      .issue_valid (Issue_Valid),
      .issue_reg   (Issue_Reg),
      .src_reg_1   (Src_Reg_1),
      .src_reg_2   (Src_Reg_2),
      .clr_en      (wr_en_q),
      .clr_reg     (wr_reg_q),
      .stall       (Stall),
      .busy        (Busy)
   );
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter with hand-computed expectations.
module tb_regfile_write_arbiter;
   logic        Clock;
   logic        Reset_n;
   logic        A_Valid, B_Valid, A_Ready, B_Ready;
   logic [4:0]  A_Reg, B_Reg, Issue_Reg, Src_Reg_1, Src_Reg_2, Write_Reg;
   logic [31:0] A_Data, B_Data, Write_Data, Busy;
   logic        Issue_Valid, Stall, Reg_Write;

   int tests_run;
   int tests_failed;

   regfile_write_arbiter dut (
      .Clock       (Clock),
      .Reset_n     (Reset_n),
      .A_Valid     (A_Valid),
      .A_Reg       (A_Reg),
      .A_Data      (A_Data),
      .A_Ready     (A_Ready),
      .B_Valid     (B_Valid),
      .B_Reg       (B_Reg),
      .B_Data      (B_Data),
      .B_Ready     (B_Ready),
      .Issue_Valid (Issue_Valid),
      .Issue_Reg   (Issue_Reg),
      .Src_Reg_1   (Src_Reg_1),
      .Src_Reg_2   (Src_Reg_2),
      .Stall       (Stall),
      .Reg_Write   (Reg_Write),
      .Write_Reg   (Write_Reg),
      .Write_Data  (Write_Data),
      .Busy        (Busy)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge Clock);
      #1;
   endtask

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      Reset_n = 1'b0;
      A_Valid = 1'b1; A_Reg = 5'd3; A_Data = 32'h0;
      B_Valid = 1'b0; B_Reg = 5'd0; B_Data = 32'h0;
      Issue_Valid = 1'b1; Issue_Reg = 5'd0; Src_Reg_1 = 5'd4; Src_Reg_2 = 5'd0;

      // reset state, with requests presented during reset
      #2;
      chk("rst_a_ready", A_Ready, 0);
      chk("rst_stall", Stall, 0);
      chk("rst_reg_write", Reg_Write, 0);
      chk("rst_busy", Busy, 0);
      tick;
      tick;
      chk("rst_held_reg_write", Reg_Write, 0);
      chk("rst_held_write_reg", Write_Reg, 0);
      A_Valid = 1'b0; Issue_Valid = 1'b0; Src_Reg_1 = 5'd0;
      Reset_n = 1'b1;

      // single ALU write
      A_Valid = 1'b1; A_Reg = 5'd8; A_Data = 32'h1234;
      #1;
      chk("a_only_a_ready", A_Ready, 1);
      chk("a_only_b_ready", B_Ready, 0);
      tick;
      A_Valid = 1'b0;
      #1;
      chk("a_only_reg_write", Reg_Write, 1);
      chk("a_only_write_reg", Write_Reg, 8);
      chk("a_only_write_data", Write_Data, 32'h1234);
      tick;
      chk("idle_reg_write", Reg_Write, 0);

      // contention: B,B,B,A,B
      A_Valid = 1'b1; A_Reg = 5'd8; A_Data = 32'hAAAA;
      B_Valid = 1'b1; B_Reg = 5'd9; B_Data = 32'hBBBB;
      for (int i = 0; i < 5; i++) begin
         #1;
         chk($sformatf("arb%0d_a_ready", i), A_Ready, (i == 3) ? 1 : 0);
         chk($sformatf("arb%0d_b_ready", i), B_Ready, (i == 3) ? 0 : 1);
         tick;
         chk($sformatf("arb%0d_write_reg", i), Write_Reg, (i == 3) ? 8 : 9);
         chk($sformatf("arb%0d_write_data", i), Write_Data, (i == 3) ? 32'hAAAA : 32'hBBBB);
      end
      A_Valid = 1'b0; B_Valid = 1'b0;

      // RAW hazard on register 10
      Issue_Valid = 1'b1; Issue_Reg = 5'd10;
      #1;
      chk("issue10_stall", Stall, 0);
      tick;
      chk("issue10_busy", Busy, 32'h0000_0400);
      Issue_Reg = 5'd11; Src_Reg_1 = 5'd10;
      #1;
      chk("raw_stall", Stall, 1);
      tick;
      chk("raw_stalled_busy", Busy, 32'h0000_0400);
      B_Valid = 1'b1; B_Reg = 5'd10; B_Data = 32'hBEEF;
      #1;
      chk("raw_b_ready", B_Ready, 1);
      chk("raw_stall_during_xfer", Stall, 1);
      tick;
      B_Valid = 1'b0;
      #1;
      chk("raw_commit_reg_write", Reg_Write, 1);
      chk("raw_commit_write_reg", Write_Reg, 10);
      chk("raw_stall_during_commit", Stall, 1);
      tick;
      chk("raw_cleared_busy", Busy, 0);
      chk("raw_released_stall", Stall, 0);
      tick;
      Issue_Valid = 1'b0; Src_Reg_1 = 5'd0;
      #1;
      chk("issue11_busy", Busy, 32'h0000_0800);

      // register 0: handshake without write, never busy, never stalls
      B_Valid = 1'b1; B_Reg = 5'd0; B_Data = 32'hFFFF_FFFF;
      #1;
      chk("r0_b_ready", B_Ready, 1);
      tick;
      B_Valid = 1'b0;
      #1;
      chk("r0_reg_write", Reg_Write, 0);
      Issue_Valid = 1'b1; Issue_Reg = 5'd0;
      #1;
      chk("r0_issue_stall", Stall, 0);
      tick;
      chk("r0_busy", Busy, 32'h0000_0800);
      Src_Reg_2 = 5'd0;
      #1;
      chk("r0_src2_stall", Stall, 0);
      Issue_Reg = 5'd11;
      #1;
      chk("waw_stall", Stall, 1);
      tick;
      Issue_Valid = 1'b0; Issue_Reg = 5'd0;
      #1;
      chk("waw_busy", Busy, 32'h0000_0800);

      // same-edge set and clear of register 12
      A_Valid = 1'b1; A_Reg = 5'd12; A_Data = 32'hC0DE;
      #1;
      chk("r12_a_ready", A_Ready, 1);
      tick;
      A_Valid = 1'b0; Issue_Valid = 1'b1; Issue_Reg = 5'd12;
      #1;
      chk("r12_reg_write", Reg_Write, 1);
      chk("r12_write_reg", Write_Reg, 12);
      chk("r12_stall", Stall, 0);
      tick;
      Issue_Valid = 1'b0; Issue_Reg = 5'd0;
      #1;
      chk("r12_set_wins_busy", Busy, 32'h0000_1800);

      // reset mid-transfer
      Reset_n = 1'b0;
      #1;
      chk("rst2_busy", Busy, 0);
      tick;
      Reset_n = 1'b1;
      Issue_Valid = 1'b1; Issue_Reg = 5'd10;
      A_Valid = 1'b1; A_Reg = 5'd5; A_Data = 32'h55;
      #1;
      chk("post_rst_first_a_ready", A_Ready, 1);
      tick;
      Issue_Valid = 1'b0; Issue_Reg = 5'd0;
      A_Reg = 5'd6; A_Data = 32'h66;
      #1;
      chk("pre_rst_busy", Busy, 32'h0000_0400);
      chk("pre_rst_write_reg", Write_Reg, 5);
      chk("pre_rst_a_ready", A_Ready, 1);
      Reset_n = 1'b0;
      #1;
      chk("mid_rst_a_ready", A_Ready, 0);
      chk("mid_rst_reg_write", Reg_Write, 0);
      chk("mid_rst_write_reg", Write_Reg, 0);
      chk("mid_rst_write_data", Write_Data, 0);
      chk("mid_rst_busy", Busy, 0);
      A_Valid = 1'b0;
      tick;
      Reset_n = 1'b1;
      tick;
      chk("discarded_reg_write", Reg_Write, 0);
      chk("discarded_write_data", Write_Data, 0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule

// File: doc/regfile_write_arbiter.md
REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
REQ-001 Parameter DATA_W, default 32, register data width.
REQ-002 Parameter ADDR_W, default 5, register index width (32 registers).
REQ-003 Parameter STARVE_MAX, default 3, max consecutive cycles port A may lose arbitration.
REQ-004 Clock  in  1  single clock; all state on rising edge.
REQ-005 Reset_n  in  1  asynchronous, active-low reset.
REQ-006 A_Valid / A_Reg / A_Data  in  1/ADDR_W/DATA_W  ALU writeback request.
REQ-007 A_Ready  out  1  A granted this cycle.
REQ-008 B_Valid / B_Reg / B_Data  in  1/ADDR_W/DATA_W  load writeback request.
REQ-009 B_Ready  out  1  B granted this cycle.
REQ-010 Issue_Valid / Issue_Reg  in  1/ADDR_W  instruction issuing, destination register to mark busy.
REQ-011 Src_Reg_1 / Src_Reg_2  in  ADDR_W  source registers of the issuing instruction.
REQ-012 Stall  out  1  hazard: issue must not proceed this cycle.
REQ-013 Reg_Write / Write_Reg / Write_Data  out  1/ADDR_W/DATA_W  registered write port to the register file.
REQ-014 Busy  out  32  scoreboard bit per register.

Function
REQ-015 A transfer occurs when X_Valid and X_Ready are both 1 in the same cycle; at most one of A_Ready/B_Ready is 1 per cycle.
REQ-016 X_Ready is combinational from Valid and arbiter state; Ready is never 1 while its Valid is 0.
REQ-017 Default priority: B over A when both valid.
REQ-018 Starve counter (0..STARVE_MAX) increments each cycle A_Valid=1 and A loses; clears when A is granted or A_Valid=0.
REQ-019 When the counter equals STARVE_MAX, A has priority that cycle (state A_FORCED); otherwise state NORMAL.
REQ-020 Write port outputs register the granted request with 1-cycle latency: handshake in cycle N gives Reg_Write=1 in cycle N+1; Reg_Write=0 in cycles after no transfer.
REQ-021 A transfer to register 0 completes the handshake but produces Reg_Write=0.
REQ-022 Issue_Valid=1 with Stall=0 sets Busy[Issue_Reg] at the next edge; register 0 is never set busy.
REQ-023 Busy[Write_Reg] clears at the edge ending a cycle with Reg_Write=1 (register file has committed).
REQ-024 Same-edge set and clear of the same register: set wins.
REQ-025 Stall=1 when Issue_Valid=1 and Busy[Src_Reg_1], Busy[Src_Reg_2] or Busy[Issue_Reg] (WAW) is 1; index 0 never stalls.
REQ-026 Stall combinational; a stalled issue does not modify Busy.
REQ-027 Write requests to a non-busy register are accepted and written normally.

Reset
REQ-028 Reset_n=0 asynchronously forces Reg_Write=0, Write_Reg=0, Write_Data=0, Busy=0, starve counter=0, state NORMAL.
REQ-029 During reset A_Ready=B_Ready=0 and Stall=0; reset mid-operation discards any granted-but-unwritten request.
REQ-030 First transfer possible in the first cycle after Reset_n rises.

Structure
REQ-031 Shared package regfile_pkg holds DATA_W, ADDR_W, ZERO_REG=0 and the arbiter state enum {NORMAL, A_FORCED}.
REQ-032 Scoreboard (Busy set/clear, hazard compare) is sub-module regfile_scoreboard; arbitration and write register stay in the top.

Verification
REQ-033 A_Valid=1 A_Reg=8 A_Data=0x1234, B idle -> A_Ready=1; next cycle Reg_Write=1 Write_Reg=8 Write_Data=0x1234.
REQ-034 A and B valid for 5 cycles (B_Reg=9) -> grants B,B,B,A,B; A_Ready in cycle 4 only.
REQ-035 Issue_Reg=10 issued; next instr Src_Reg_1=10 -> Stall=1 until the edge after Reg_Write=1 Write_Reg=10, then Stall=0.
REQ-036 B_Reg=0 B_Data=0xFFFFFFFF -> B_Ready=1, Reg_Write stays 0; Issue_Reg=0 then Src_Reg_2=0 -> Stall=0.
REQ-037 Same-edge Issue_Reg=12 and Reg_Write=1 Write_Reg=12 -> Busy[12]=1 after edge.
REQ-038 Reset_n=0 mid-transfer with Busy=0x00000400 -> all outputs 0 immediately, Busy=0.
